matmul_feeder: RTL and testbench
================================

# matmul_feeder

Operand sequencer that sits directly upstream of the 3x3 MAC-array multiplier and drives its `data_w1..3`, `data_x1..3`, `load` and `clear` inputs. It holds two 3x3 operand matrices W and X, each loaded through a simple write port. On `start` it clears the array, then streams three outer-product steps so that MAC(i,j) accumulates C[i][j] = sum over k of W[i][k]*X[k][j]. It signals completion with `done`.

## Interface
- `DATA_W`, default 4: element width of W and X and of all `data_*` outputs.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  operand write strobe.
- `wr_sel`  in  1  target matrix: 0 = W, 1 = X.
- `wr_addr`  in  4  element index, row-major: addr = 3*row + col, valid range 0..8.
- `wr_data`  in  DATA_W  element value.
- `start`  in  1  begin a multiply sequence.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `data_w1`, `data_w2`, `data_w3`  out  DATA_W each  W column k, rows 1..3.
- `data_x1`, `data_x2`, `data_x3`  out  DATA_W each  X row k, columns 1..3.
- `load`  out  1  MAC accumulate enable.
- `clear`  out  1  MAC accumulator clear.
- `accum`  in  1  present only when `MATMUL_FEEDER_ACC_EN` is defined; see Configuration.

## Operation
- Storage: eighteen DATA_W registers, W[0..8] and X[0..8]. Reset value of every register is 0.
- Writes:
  - A write is committed on the edge where `wr_en` = 1, `busy` = 0 and `wr_addr` <= 8.
  - A write with `wr_addr` of 9..15 is ignored.
  - A write while `busy` = 1 is ignored.
- FSM states: IDLE, CLR, FEED, DRAIN, DONE. FEED uses a 2-bit step counter k = 0..2.
- Transitions:
  - IDLE or DONE, with `start` = 1 → CLR.
  - IDLE, with `start` = 0 → IDLE.
  - DONE, with `start` = 0 → IDLE.
  - CLR → FEED with k = 0.
  - FEED, k < 2 → FEED with k + 1.
  - FEED, k = 2 → DRAIN.
  - DRAIN → DONE.
- `start` is ignored in CLR, FEED and DRAIN.
- All outputs are registered and decoded from state:
  - CLR: `clear` = 1, `load` = 0.
  - FEED step k: `load` = 1; `data_w{i+1}` = W[3i+k]; `data_x{j+1}` = X[3k+j].
  - Every state other than FEED: `load` = 0 and all `data_*` = 0.
  - `busy` = 1 in CLR, FEED and DRAIN.
  - `done` = 1 in DONE only.
- Simultaneous write and start in IDLE: the write commits on the same edge that starts the sequence, so FEED uses the new value.
- Reset at any time, including mid-FEED:
  - All outputs go to 0 immediately.
  - State returns to IDLE and operand registers are cleared.
  - The MAC array contents are not this block's responsibility. The next sequence begins with CLR unless accumulate mode applies.

## Timing
- Let cycle 0 be the cycle in which `start` is sampled high. Cycle n begins after the n-th following rising edge.
  - Cycle 1: `clear` = 1, `busy` = 1.
  - Cycles 2, 3, 4: `load` = 1 with k = 0, 1, 2.
  - Cycle 5: DRAIN, `busy` = 1. This gives the MAC array one edge to register the final accumulation.
  - Cycle 6: `done` = 1, `busy` = 0.
- Total latency from start to done is 6 cycles.
- A back-to-back `start` sampled in the DONE cycle puts CLR in the next cycle. Throughput is one sequence per 6 cycles.
- Reset values: `busy`, `done`, `load`, `clear` and all `data_*` are 0.

## Configuration
- `MATMUL_FEEDER_ACC_EN` defined:
  - Adds the `accum` input, sampled together with `start`.
  - With `accum` = 1, CLR is skipped: the sequence goes IDLE/DONE → FEED directly, so the MAC array computes C += W*X.
  - In that case latency is 5 cycles: `load` in cycles 1–3, DRAIN in cycle 4, `done` in cycle 5.
  - With `accum` = 0, behaviour matches the undefined case.
- `MATMUL_FEEDER_ACC_EN` undefined: the port is absent and every sequence begins with CLR.

## Test plan
- Basic multiply: write W = [1,2,3;4,5,6;7,8,9] and X = identity, pulse `start`.
  - Cycle 1 has `clear` = 1.
  - Cycle 2 shows w = (1,4,7), x = (1,0,0).
  - Cycle 3 shows w = (2,5,8), x = (0,1,0).
  - Cycle 4 shows w = (3,6,9), x = (0,0,1).
  - `done` = 1 in cycle 6.
  - A downstream MAC model holds C = W.
- Write protection: attempt a write to W[0] = 15 during FEED, and a write to `wr_addr` = 12 in IDLE. The next sequence shows W[0] unchanged, and no register has changed.
- Start while busy: pulse `start` in cycle 3. There is no restart, and `done` still arrives in cycle 6. Then start in the DONE cycle: `clear` = 1 in the following cycle.
- Reset mid-operation: assert `rst` in cycle 3.
  - All outputs go to 0 asynchronously.
  - After release, `busy` = 0 and a new start behaves as in the basic test, with all operands 0.
- Same-edge write and start: write X[4] = 9 together with `start`. Cycle 3 shows `data_x2` = 9.
- With `MATMUL_FEEDER_ACC_EN`: run the basic multiply twice, the second with `accum` = 1. There is no `clear`, `done` arrives in cycle 5, and the MAC model holds C = 2W.

Source files
------------

// File: rtl/matmul_feeder.sv
// matmul_feeder: operand sequencer for a 3x3 MAC array.
// Holds W and X (3x3, row-major), and on start clears the array and streams
// three outer-product steps so MAC(i,j) accumulates sum_k W[i][k]*X[k][j].
// Optional feature macro: MATMUL_FEEDER_ACC_EN adds an 'accum' input that
// skips the clear step so the array computes C += W*X.
module matmul_feeder #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
`ifdef MATMUL_FEEDER_ACC_EN
    input  logic              accum,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_w1,
    output logic [DATA_W-1:0] data_w2,
    output logic [DATA_W-1:0] data_w3,
    output logic [DATA_W-1:0] data_x1,
    output logic [DATA_W-1:0] data_x2,
    output logic [DATA_W-1:0] data_x3,
    output logic              load,
    output logic              clear
);

    typedef enum logic [2:0] {StIdle, StClr, StFeed, StDrain, StDone} state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] w_q [9];
    logic [DATA_W-1:0] w_d [9];
    logic [DATA_W-1:0] x_q [9];
    logic [DATA_W-1:0] x_d [9];
    logic              acc_req;
    logic              wr_ok;
    logic [3:0]        kk, k3;

    logic              busy_d, done_d, load_d, clear_d;
    logic [DATA_W-1:0] w1_d, w2_d, w3_d, x1_d, x2_d, x3_d;

`ifdef MATMUL_FEEDER_ACC_EN
    assign acc_req = accum;
`else
    assign acc_req = 1'b0;
`endif

    // Writes are only accepted while idle and for in-range addresses.
    assign wr_ok = wr_en && !busy && (wr_addr <= 4'd8);

    // Next operand register contents, including the write landing this edge.
    always_comb begin
        w_d = w_q;
        x_d = x_q;
        if (wr_ok) begin
            if (wr_sel) x_d[wr_addr] = wr_data;
            else        w_d[wr_addr] = wr_data;
        end
    end

    // Next-state logic for the sequencer and its step counter.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    k_d     = 2'd0;
                    state_d = acc_req ? StFeed : StClr;
                end else begin
                    state_d = StIdle;
                end
            end
            StClr: begin
                state_d = StFeed;
                k_d     = 2'd0;
            end
            StFeed: begin
                if (k_q == 2'd2) state_d = StDrain;
                else             k_d = k_q + 2'd1;
            end
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Output values decoded from the next state; operands come from the
    // post-write registers so a write on the start edge is seen by FEED.
    always_comb begin
        kk      = {2'b00, k_d};
        k3      = {1'b0, k_d, 1'b0} + kk;
        busy_d  = (state_d == StClr) || (state_d == StFeed) || (state_d == StDrain);
        done_d  = (state_d == StDone);
        clear_d = (state_d == StClr);
        load_d  = (state_d == StFeed);
        w1_d    = '0;
        w2_d    = '0;
        w3_d    = '0;
        x1_d    = '0;
        x2_d    = '0;
        x3_d    = '0;
        if (state_d == StFeed) begin
            w1_d = w_d[kk];
            w2_d = w_d[kk + 4'd3];
            w3_d = w_d[kk + 4'd6];
            x1_d = x_d[k3];
            x2_d = x_d[k3 + 4'd1];
            x3_d = x_d[k3 + 4'd2];
        end
    end

    // State, operand storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= 2'd0;
            for (int i = 0; i < 9; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
            busy    <= 1'b0;
            done    <= 1'b0;
            load    <= 1'b0;
            clear   <= 1'b0;
            data_w1 <= '0;
            data_w2 <= '0;
            data_w3 <= '0;
            data_x1 <= '0;
            data_x2 <= '0;
            data_x3 <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            x_q     <= x_d;
            busy    <= busy_d;
            done    <= done_d;
            load    <= load_d;
            clear   <= clear_d;
            data_w1 <= w1_d;
            data_w2 <= w2_d;
            data_w3 <= w3_d;
            data_x1 <= x1_d;
            data_x2 <= x2_d;
            data_x3 <= x3_d;
        end
    end

endmodule

// File: tb/tb_matmul_feeder.sv
// Self-checking bench for matmul_feeder: per-cycle control table, a
// scoreboard of expected FEED operands, and a downstream MAC array model.
module tb_matmul_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] wr_data = 4'd0;
    logic       start = 1'b0;
    logic       accum = 1'b0;
    logic       busy, done, load, clear;
    logic [3:0] data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;

    matmul_feeder #(.DATA_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
`ifdef MATMUL_FEEDER_ACC_EN
        .accum   (accum),
`endif
        .busy    (busy),
        .done    (done),
        .data_w1 (data_w1),
        .data_w2 (data_w2),
        .data_w3 (data_w3),
        .data_x1 (data_x1),
        .data_x2 (data_x2),
        .data_x3 (data_x3),
        .load    (load),
        .clear   (clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic clear;
        logic load;
        logic busy;
        logic done;
    } row_t;

    typedef struct {
        int w1, w2, w3, x1, x2, x3;
    } feed_t;

    row_t  tbl_clr [7];
    row_t  tbl_acc [6];
    feed_t sb [$];
    int    sw [9];
    int    sx [9];
    int    exp_c [3][3];
    int    mac_c [3][3];
    int    n_pass = 0;
    int    n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Downstream MAC array model driven only by the DUT outputs.
    always @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) mac_c[i][j] = 0;
        end else if (load) begin
            int wv[3];
            int xv[3];
            wv[0] = int'(data_w1); wv[1] = int'(data_w2); wv[2] = int'(data_w3);
            xv[0] = int'(data_x1); xv[1] = int'(data_x2); xv[2] = int'(data_x3);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) mac_c[i][j] += wv[i] * xv[j];
        end
    end

    // Scoreboard: every FEED step pops one expected operand set.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                feed_t e;
                e = sb.pop_front();
                chk("data_w1", int'(data_w1), e.w1);
                chk("data_w2", int'(data_w2), e.w2);
                chk("data_w3", int'(data_w3), e.w3);
                chk("data_x1", int'(data_x1), e.x1);
                chk("data_x2", int'(data_x2), e.x2);
                chk("data_x3", int'(data_x3), e.x3);
            end
        end
    end

    function automatic int all_outs();
        return int'({busy, done, load, clear, data_w1, data_w2, data_w3,
                     data_x1, data_x2, data_x3});
    endfunction

    task automatic do_write(input logic sel, input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = 4'(data);
        if (addr <= 8) begin
            if (sel) sx[addr] = data;
            else     sw[addr] = data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Drives start (and optionally a same-edge write) in the current cycle.
    task automatic begin_seq(input bit acc, input bit do_wr, input logic sel,
                             input int addr, input int data);
        feed_t e;
        if (do_wr) begin
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_addr = 4'(addr);
            wr_data = 4'(data);
            if (addr <= 8) begin
                if (sel) sx[addr] = data;
                else     sw[addr] = data;
            end
        end
        start = 1'b1;
        accum = acc;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s = 0;
                for (int k = 0; k < 3; k++) s += sw[3*i+k] * sx[3*k+j];
                exp_c[i][j] = (acc ? exp_c[i][j] : 0) + s;
            end
        for (int k = 0; k < 3; k++) begin
            e.w1 = sw[k];     e.w2 = sw[3+k];   e.w3 = sw[6+k];
            e.x1 = sx[3*k];   e.x2 = sx[3*k+1]; e.x3 = sx[3*k+2];
            sb.push_back(e);
        end
    endtask

    task automatic start_seq(input bit acc, input bit do_wr, input logic sel,
                             input int addr, input int data);
        @(negedge clk);
        begin_seq(acc, do_wr, sel, addr, data);
    endtask

    // Walks cycles 1..done against the control table, with optional
    // disturbances injected in a given cycle.
    task automatic check_cycles(input bit acc, input int restart_cyc, input int wr_cyc,
                                input int rst_cyc, input bit b2b);
        int   n_cyc;
        row_t r;
        n_cyc = acc ? 5 : 6;
        for (int n = 1; n <= n_cyc; n++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            accum = 1'b0;
            r = acc ? tbl_acc[n] : tbl_clr[n];
            chk($sformatf("clear_c%0d", n), int'(clear), int'(r.clear));
            chk($sformatf("load_c%0d", n), int'(load), int'(r.load));
            chk($sformatf("busy_c%0d", n), int'(busy), int'(r.busy));
            chk($sformatf("done_c%0d", n), int'(done), int'(r.done));
            if (!r.load)
                chk($sformatf("data_zero_c%0d", n),
                    int'({data_w1, data_w2, data_w3, data_x1, data_x2, data_x3}), 0);
            if (n == restart_cyc) start = 1'b1;
            if (n == wr_cyc) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 4'd15;
            end
            if (n == rst_cyc) begin
                rst = 1'b1;
                #1;
                chk("outs_zero_in_reset", all_outs(), 0);
                sb.delete();
                for (int i = 0; i < 9; i++) begin sw[i] = 0; sx[i] = 0; end
                return;
            end
            if (n == n_cyc) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        chk($sformatf("mac_c%0d%0d", i, j), mac_c[i][j], exp_c[i][j]);
                if (b2b) begin_seq(1'b0, 1'b0, 1'b0, 0, 0);
            end
        end
    endtask

    task automatic load_basic();
        for (int a = 0; a < 9; a++) do_write(1'b0, a, a + 1);
        for (int a = 0; a < 9; a++) do_write(1'b1, a, (a % 4 == 0) ? 1 : 0);
    endtask

    initial begin
        // Control table: cycle -> {clear, load, busy, done}.
        tbl_clr[0] = '{0, 0, 0, 0};
        tbl_clr[1] = '{1, 0, 1, 0};
        tbl_clr[2] = '{0, 1, 1, 0};
        tbl_clr[3] = '{0, 1, 1, 0};
        tbl_clr[4] = '{0, 1, 1, 0};
        tbl_clr[5] = '{0, 0, 1, 0};
        tbl_clr[6] = '{0, 0, 0, 1};
        tbl_acc[0] = '{0, 0, 0, 0};
        tbl_acc[1] = '{0, 1, 1, 0};
        tbl_acc[2] = '{0, 1, 1, 0};
        tbl_acc[3] = '{0, 1, 1, 0};
        tbl_acc[4] = '{0, 0, 1, 0};
        tbl_acc[5] = '{0, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin sw[i] = 0; sx[i] = 0; end

        rst = 1'b1;
        @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        rst = 1'b0;

        // Basic multiply: W = 1..9, X = identity.
        load_basic();
        start_seq(1'b0, 1'b0, 1'b0, 0, 0);
        check_cycles(1'b0, 0, 0, 0, 1'b0);

        // Write protection: out-of-range write in IDLE, W[0] write during FEED.
        do_write(1'b0, 12, 5);
        start_seq(1'b0, 1'b0, 1'b0, 0, 0);
        check_cycles(1'b0, 0, 2, 0, 1'b0);
        start_seq(1'b0, 1'b0, 1'b0, 0, 0);
        check_cycles(1'b0, 0, 0, 0, 1'b0);

        // Start while busy is ignored; start in DONE runs back-to-back.
        start_seq(1'b0, 1'b0, 1'b0, 0, 0);
        check_cycles(1'b0, 3, 0, 0, 1'b1);
        check_cycles(1'b0, 0, 0, 0, 1'b0);

        // Same-edge write X[4] = 9 with start.
        start_seq(1'b0, 1'b1, 1'b1, 4, 9);
        check_cycles(1'b0, 0, 0, 0, 1'b0);

        // Reset mid-FEED, then a clean run with all-zero operands.
        start_seq(1'b0, 1'b0, 1'b0, 0, 0);
        check_cycles(1'b0, 0, 0, 3, 1'b0);
        @(negedge clk);
        chk("outs_zero_held_reset", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_reset", int'(busy), 0);
        start_seq(1'b0, 1'b0, 1'b0, 0, 0);
        check_cycles(1'b0, 0, 0, 0, 1'b0);

`ifdef MATMUL_FEEDER_ACC_EN
        // Accumulate mode: second pass skips clear, C = 2W.
        load_basic();
        start_seq(1'b0, 1'b0, 1'b0, 0, 0);
        check_cycles(1'b0, 0, 0, 0, 1'b0);
        start_seq(1'b1, 1'b0, 1'b0, 0, 0);
        check_cycles(1'b1, 0, 0, 0, 1'b0);
`endif

        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
